// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D memory-port arbiter.
// Size codes, FSM state encodings, owner ids and the latched command.
package mem_arbiter_pkg;

    localparam logic [2:0] BHW_BYTE = 3'b001;
    localparam logic [2:0] BHW_HALF = 3'b010;
    localparam logic [2:0] BHW_WORD = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [2:0]  bhw;
        logic        wr;
    } cmd_t;

    function automatic logic bhw_ok(input logic [2:0] b);
        return (b == BHW_BYTE) || (b == BHW_HALF) || (b == BHW_WORD);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// Ports: i_req_i/d_req_i requests, last_i last owner, gnt_i_o/gnt_d_o one-hot grant.
module mem_arbiter_rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic   i_req_i,
    input  logic   d_req_i,
    input  owner_t last_i,
    output logic   gnt_i_o,
    output logic   gnt_d_o
);

    // On a tie the requester that did not win last time gets the port.
    assign gnt_i_o = i_req_i & (~d_req_i | (last_i == OWNER_D));
    assign gnt_d_o = d_req_i & (~i_req_i | (last_i == OWNER_I));

endmodule

// File: rtl/mem_arbiter.sv
// Shares the mainMemory port between instruction fetch (I) and data (D).
// Ports: CLK/RST, i_* fetch side, d_* data side, err, mem_* memory side.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_req,
    input  logic [31:0] i_adr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr_nrd,
    input  logic [2:0]  d_bhw,
    input  logic [31:0] d_adr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        mem_request,
    output logic [2:0]  mem_bhw,
    output logic        mem_WR_nRD,
    output logic [31:0] mem_ADR,
    output logic [31:0] mem_DATA,
    input  logic [31:0] mem_DATAOUT,
    input  logic        mem_send
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    owner_t             last_q, last_d;
    owner_t             owner_q, owner_d;
    cmd_t               cmd_q, cmd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               abort_d;
    logic [31:0]        rdata_d;
    logic               sel_i, sel_d;

    logic               mem_request_q, mem_request_d;
    logic               i_ack_q, i_ack_d;
    logic               d_ack_q, d_ack_d;
    logic               err_q, err_d;
    logic [31:0]        i_rdata_q, i_rdata_d;
    logic [31:0]        d_rdata_q, d_rdata_d;

    mem_arbiter_rr_arb2 u_rr (
        .i_req_i (i_req),
        .d_req_i (d_req),
        .last_i  (last_q),
        .gnt_i_o (sel_i),
        .gnt_d_o (sel_d)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= IDLE;
            last_q        <= OWNER_D;
            owner_q       <= OWNER_I;
            cmd_q         <= '0;
            cnt_q         <= '0;
            mem_request_q <= 1'b0;
            i_ack_q       <= 1'b0;
            d_ack_q       <= 1'b0;
            err_q         <= 1'b0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            owner_q       <= owner_d;
            cmd_q         <= cmd_d;
            cnt_q         <= cnt_d;
            mem_request_q <= mem_request_d;
            i_ack_q       <= i_ack_d;
            d_ack_q       <= d_ack_d;
            err_q         <= err_d;
            i_rdata_q     <= i_rdata_d;
            d_rdata_q     <= d_rdata_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        abort_d = 1'b0;
        rdata_d = '0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sel_i) begin
                    owner_d = OWNER_I;
                    last_d  = OWNER_I;
                    cmd_d   = '{adr: i_adr, wdata: '0, bhw: BHW_WORD, wr: 1'b0};
                    state_d = BUSY;
                end else if (sel_d) begin
                    owner_d = OWNER_D;
                    last_d  = OWNER_D;
                    cmd_d   = '{adr: d_adr, wdata: d_wdata, bhw: d_bhw, wr: d_wr_nrd};
                    // An illegal size never touches memory; it is answered in GAP.
                    if (bhw_ok(d_bhw)) begin
                        state_d = BUSY;
                    end else begin
                        state_d = GAP;
                        abort_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_send) begin
                    state_d = GAP;
                    rdata_d = cmd_q.wr ? '0 : mem_DATAOUT;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = GAP;
                    abort_d = 1'b1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // GAP always lasts one cycle, so entering it is exactly the ack cycle.
    always_comb begin : out_comb
        mem_request_d = (state_d == BUSY);
        i_ack_d       = (state_d == GAP) && (owner_d == OWNER_I);
        d_ack_d       = (state_d == GAP) && (owner_d == OWNER_D);
        err_d         = abort_d;
        i_rdata_d     = i_ack_d ? rdata_d : i_rdata_q;
        d_rdata_d     = d_ack_d ? rdata_d : d_rdata_q;
    end

    assign mem_request = mem_request_q;
    assign mem_bhw     = cmd_q.bhw;
    assign mem_WR_nRD  = cmd_q.wr;
    assign mem_ADR     = cmd_q.adr;
    assign mem_DATA    = cmd_q.wdata;
    assign i_ack       = i_ack_q;
    assign d_ack       = d_ack_q;
    assign err         = err_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural mainMemory.
// Table-driven single accesses plus tie, timeout and reset sequences.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_adr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_wr_nrd = 1'b0;
    logic [2:0]  d_bhw = '0;
    logic [31:0] d_adr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        err;
    logic        mem_request;
    logic [2:0]  mem_bhw;
    logic        mem_WR_nRD;
    logic [31:0] mem_ADR;
    logic [31:0] mem_DATA;
    logic [31:0] mem_DATAOUT = '0;
    logic        mem_send;

    mem_arbiter #(.TIMEOUT(8), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST),
        .i_req(i_req), .i_adr(i_adr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr_nrd(d_wr_nrd), .d_bhw(d_bhw), .d_adr(d_adr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .mem_request(mem_request), .mem_bhw(mem_bhw), .mem_WR_nRD(mem_WR_nRD),
        .mem_ADR(mem_ADR), .mem_DATA(mem_DATA), .mem_DATAOUT(mem_DATAOUT),
        .mem_send(mem_send)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural mainMemory ----------------
    logic [31:0] mem [0:255] = '{4: 32'hDEADBEEF, default: 32'h0};
    logic        model_send = 1'b0;
    logic        late_send = 1'b0;
    logic        req_prev = 1'b0;
    bit          mem_en = 1'b1;
    int          lat = 1;
    int          mcnt = 0;

    assign mem_send = model_send | late_send;

    function automatic logic [31:0] mrd(input logic [31:0] w, input logic [2:0] b,
                                        input logic [1:0] a);
        case (b)
            3'b001:  return {24'h0, w[8*int'(a) +: 8]};
            3'b010:  return {16'h0, a[1] ? w[31:16] : w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] mwr(input logic [31:0] w, input logic [31:0] d,
                                        input logic [2:0] b, input logic [1:0] a);
        logic [31:0] r;
        r = w;
        case (b)
            3'b001: r[8*int'(a) +: 8] = d[7:0];
            3'b010: if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    always @(posedge CLK) begin
        model_send <= 1'b0;
        req_prev   <= mem_request;
        if (!mem_request) begin
            mcnt <= 0;
        end else if (!req_prev) begin
            mcnt <= mem_en ? lat : 0;
        end else if (mcnt == 1) begin
            mcnt       <= 0;
            model_send <= 1'b1;
            if (mem_WR_nRD) begin
                mem[mem_ADR[9:2]] <= mwr(mem[mem_ADR[9:2]], mem_DATA, mem_bhw, mem_ADR[1:0]);
                mem_DATAOUT <= 32'hFFFF_FFFF;
            end else begin
                mem_DATAOUT <= mrd(mem[mem_ADR[9:2]], mem_bhw, mem_ADR[1:0]);
            end
        end else if (mcnt > 1) begin
            mcnt <= mcnt - 1;
        end
    end

    // Ack-cycle invariants: exactly one ack, and err only with an ack.
    always @(negedge CLK) begin
        if (!RST && (i_ack || d_ack || err)) begin
            chk("ack_excl", {31'b0, i_ack & d_ack}, 32'h0);
            chk("err_no_ack", {31'b0, err & ~(i_ack | d_ack)}, 32'h0);
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          own_d;
        logic [31:0] rdata;
        bit          err;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [2:0]  bhw;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
    } vec_t;
    vec_t vt[12];

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s_sb: got ack want none", tag);
            return;
        end
        e = sbq.pop_front();
        chk({tag, "_owner"}, {30'b0, i_ack, d_ack}, e.own_d ? 32'h1 : 32'h2);
        chk({tag, "_rdata"}, e.own_d ? d_rdata : i_rdata, e.rdata);
        chk({tag, "_err"}, {31'b0, err}, {31'b0, e.err});
    endtask

    task automatic run_vec(input vec_t v, input int id);
        exp_t        e;
        bit          got, saw;
        logic        prev_send;
        logic [31:0] cadr;
        logic [2:0]  cbhw;
        logic        cwr;
        string       tag;
        tag = $sformatf("v%0d", id);
        e.own_d = v.is_d; e.rdata = v.rdata; e.err = v.err;
        sbq.push_back(e);
        if (v.is_d) begin
            d_wr_nrd = v.wr; d_bhw = v.bhw; d_adr = v.adr; d_wdata = v.wdata; d_req = 1'b1;
        end else begin
            i_adr = v.adr; i_req = 1'b1;
        end
        got = 0; saw = 0; prev_send = 0; cadr = '0; cbhw = '0; cwr = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(posedge CLK); #1;
            if (mem_request && !saw) begin
                saw = 1; cadr = mem_ADR; cbhw = mem_bhw; cwr = mem_WR_nRD;
            end
            if (i_ack || d_ack) begin
                got = 1; i_req = 1'b0; d_req = 1'b0;
                pop_cmp(tag);
                chk({tag, "_memreq"}, {31'b0, saw}, {31'b0, ~v.err});
                if (!v.err) begin
                    chk({tag, "_adr"}, cadr, v.adr);
                    chk({tag, "_bhw"}, {29'b0, cbhw}, {29'b0, v.is_d ? v.bhw : 3'b100});
                    chk({tag, "_wr"}, {31'b0, cwr}, {31'b0, v.is_d & v.wr});
                    chk({tag, "_ack_after_send"}, {31'b0, prev_send}, 32'h1);
                end
            end
            prev_send = mem_send;
        end
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL %s_noack: got none want ack", tag);
            i_req = 1'b0; d_req = 1'b0;
            if (sbq.size() > 0) void'(sbq.pop_front());
        end
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   n, cnt;
        bit   i_drop, d_drop, any;

        vt[0]  = '{0, 0, 3'b100, 32'h10, 32'h0,        32'hDEADBEEF, 0};
        vt[1]  = '{1, 1, 3'b100, 32'h40, 32'hCAFEF00D, 32'h0,        0};
        vt[2]  = '{1, 0, 3'b100, 32'h40, 32'h0,        32'hCAFEF00D, 0};
        vt[3]  = '{1, 1, 3'b001, 32'h41, 32'h000000AB, 32'h0,        0};
        vt[4]  = '{1, 0, 3'b001, 32'h41, 32'h0,        32'h000000AB, 0};
        vt[5]  = '{1, 0, 3'b100, 32'h40, 32'h0,        32'hCAFEAB0D, 0};
        vt[6]  = '{1, 1, 3'b010, 32'h20, 32'h00001234, 32'h0,        0};
        vt[7]  = '{1, 0, 3'b010, 32'h20, 32'h0,        32'h00001234, 0};
        vt[8]  = '{0, 0, 3'b100, 32'h40, 32'h0,        32'hCAFEAB0D, 0};
        vt[9]  = '{1, 0, 3'b011, 32'h40, 32'h0,        32'h0,        1};
        vt[10] = '{1, 1, 3'b000, 32'h44, 32'h55,       32'h0,        1};
        vt[11] = '{1, 0, 3'b010, 32'h42, 32'h0,        32'h0000CAFE, 0};

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ctl", {26'b0, i_ack, d_ack, err, mem_request, mem_WR_nRD, 1'b0}, 32'h0);
        chk("rst_bhw", {29'b0, mem_bhw}, 32'h0);
        chk("rst_adr", mem_ADR, 32'h0);
        chk("rst_data", mem_DATA, 32'h0);
        chk("rst_irdata", i_rdata, 32'h0);
        chk("rst_drdata", d_rdata, 32'h0);
        RST = 1'b0;

        for (int k = 0; k < 12; k++) run_vec(vt[k], k);

        // Tie out of reset, then both held: expect I, D, I, D
        do_reset();
        i_adr = 32'h10;
        d_wr_nrd = 1'b0; d_bhw = 3'b100; d_adr = 32'h40;
        for (int k = 0; k < 4; k++) begin
            e.own_d = k[0]; e.err = 0;
            e.rdata = k[0] ? 32'hCAFEAB0D : 32'hDEADBEEF;
            sbq.push_back(e);
        end
        i_req = 1'b1; d_req = 1'b1;
        n = 0; i_drop = 0; d_drop = 0;
        for (int c = 0; c < 300 && n < 4; c++) begin
            @(posedge CLK); #1;
            if (i_drop) begin i_req = 1'b1; i_drop = 0; end
            if (d_drop) begin d_req = 1'b1; d_drop = 0; end
            if (i_ack || d_ack) begin
                pop_cmp($sformatf("tie%0d", n));
                if (i_ack) begin i_req = 1'b0; i_drop = 1; end
                if (d_ack) begin d_req = 1'b0; d_drop = 1; end
                n++;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        chk("tie_count", n, 4);
        while (sbq.size() > 0) void'(sbq.pop_front());
        @(posedge CLK); #1;

        // Timeout: memory never answers
        mem_en = 0;
        d_wr_nrd = 1'b0; d_bhw = 3'b100; d_adr = 32'h40;
        e.own_d = 1; e.rdata = 32'h0; e.err = 1;
        sbq.push_back(e);
        d_req = 1'b1;
        cnt = 0; any = 0;
        for (int c = 0; c < 100 && !any; c++) begin
            @(posedge CLK); #1;
            if (mem_request) cnt++;
            if (i_ack || d_ack) begin
                any = 1; d_req = 1'b0;
                pop_cmp("tmo");
            end
        end
        d_req = 1'b0;
        chk("tmo_acked", {31'b0, any}, 32'h1);
        chk("tmo_req_cycles", cnt, 8);
        mem_en = 1;
        @(posedge CLK); #1;
        late_send = 1'b1;
        @(posedge CLK); #1;
        late_send = 1'b0;
        any = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK); #1;
            if (i_ack || d_ack || err) any = 1;
        end
        chk("late_send_noack", {31'b0, any}, 32'h0);
        while (sbq.size() > 0) void'(sbq.pop_front());

        // Reset mid-BUSY
        lat = 20;
        i_adr = 32'h10;
        i_req = 1'b1;
        any = 0;
        for (int c = 0; c < 10 && !mem_request; c++) begin
            @(posedge CLK); #1;
        end
        chk("rstb_busy", {31'b0, mem_request}, 32'h1);
        repeat (2) @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        chk("rstb_req_drop", {31'b0, mem_request}, 32'h0);
        chk("rstb_acks", {29'b0, i_ack, d_ack, err}, 32'h0);
        lat = 1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        e.own_d = 0; e.rdata = 32'hDEADBEEF; e.err = 0;
        sbq.push_back(e);
        for (int c = 0; c < 50 && !any; c++) begin
            @(posedge CLK); #1;
            if (i_ack || d_ack) begin
                any = 1; i_req = 1'b0;
                pop_cmp("rstb_fetch");
            end
        end
        i_req = 1'b0;
        chk("rstb_fetch_done", {31'b0, any}, 32'h1);
        repeat (3) @(posedge CLK);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
